// File: rtl/i2c_slave_regs.sv
// ============================================================================
// Module      : i2c_slave_regs
// Description : Oversampled I2C target exposing four 8-bit registers through
//               an auto-incrementing 2-bit pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter logic [31:0] RESET_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  inout  wire         SDA,
  output logic [31:0] regs_out,
  output logic        wr_strobe,
  output logic [1:0]  wr_ptr,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RACK      = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  localparam logic [3:0] c_last_bit = 4'd7;
  localparam logic [3:0] c_byte_len = 4'd8;

  state_t      r_state, w_state;
  logic [3:0]  r_bit_cnt, w_bit_cnt;
  logic [7:0]  r_shift, w_shift;
  logic [1:0]  r_ptr, w_ptr;
  logic [31:0] r_regs, w_regs;
  logic        r_sda_oe, w_sda_oe;
  logic        r_busy, w_busy;
  logic        r_wr_strobe, w_wr_strobe;
  logic [1:0]  r_wr_ptr, w_wr_ptr;
  logic        r_ack_flag, w_ack_flag;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte, w_cur;

  // Synchronizers idle high so a reset never fabricates a START/STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= SCL;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= SDA;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
  assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_cur      = r_regs[{r_ptr, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_ptr       <= 2'd0;
      r_regs      <= RESET_VAL;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_ptr    <= 2'd0;
      r_ack_flag  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bit_cnt   <= w_bit_cnt;
      r_shift     <= w_shift;
      r_ptr       <= w_ptr;
      r_regs      <= w_regs;
      r_sda_oe    <= w_sda_oe;
      r_busy      <= w_busy;
      r_wr_strobe <= w_wr_strobe;
      r_wr_ptr    <= w_wr_ptr;
      r_ack_flag  <= w_ack_flag;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_bit_cnt   = r_bit_cnt;
    w_shift     = r_shift;
    w_ptr       = r_ptr;
    w_regs      = r_regs;
    w_sda_oe    = r_sda_oe;
    w_busy      = r_busy;
    w_wr_strobe = 1'b0;
    w_wr_ptr    = r_wr_ptr;
    w_ack_flag  = r_ack_flag;

    if (w_start) begin
      w_state    = S_ADDR;
      w_bit_cnt  = 4'd0;
      w_sda_oe   = 1'b0;
      w_busy     = 1'b0;
      w_ack_flag = 1'b0;
    end else if (w_stop) begin
      w_state    = S_IDLE;
      w_bit_cnt  = 4'd0;
      w_sda_oe   = 1'b0;
      w_busy     = 1'b0;
      w_ack_flag = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift    = w_byte;
            w_bit_cnt  = r_bit_cnt + 4'd1;
            w_ack_flag = 1'b0;
            if (r_bit_cnt == c_last_bit) begin
              if (r_state == S_ADDR) begin
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  w_state = S_ADDR_ACK;
                  w_busy  = 1'b1;
                end else begin
                  w_state = S_IGNORE;
                end
              end else if (r_state == S_PTR) begin
                w_ptr   = w_byte[1:0];
                w_state = S_PTR_ACK;
              end else begin
                w_regs[{r_ptr, 3'b000} +: 8] = w_byte;
                w_wr_strobe = 1'b1;
                w_wr_ptr    = r_ptr;
                w_ptr       = r_ptr + 2'd1;
                w_state     = S_WDATA_ACK;
              end
            end
          end
        end

        // First falling edge starts the ACK low, the second one ends it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_flag) begin
              w_sda_oe   = 1'b1;
              w_ack_flag = 1'b1;
            end else begin
              w_ack_flag = 1'b0;
              w_bit_cnt  = 4'd0;
              if (r_state == S_ADDR_ACK && r_shift[0]) begin
                w_shift   = {w_cur[6:0], 1'b0};
                w_sda_oe  = ~w_cur[7];
                w_ptr     = r_ptr + 2'd1;
                w_bit_cnt = 4'd1;
                w_state   = S_RDATA;
              end else begin
                w_sda_oe = 1'b0;
                w_state  = (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
              end
            end
          end
        end

        S_RDATA: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == c_byte_len) begin
              w_sda_oe   = 1'b0;
              w_ack_flag = 1'b0;
              w_state    = S_RACK;
            end else begin
              w_sda_oe  = ~r_shift[7];
              w_shift   = {r_shift[6:0], 1'b0};
              w_bit_cnt = r_bit_cnt + 4'd1;
            end
          end
        end

        // ack_flag here records that the master acknowledged the byte.
        S_RACK: begin
          if (w_scl_rise) begin
            if (r_sda_s2) begin
              w_state = S_IGNORE;
              w_busy  = 1'b0;
            end else begin
              w_ack_flag = 1'b1;
            end
          end else if (w_scl_fall && r_ack_flag) begin
            w_ack_flag = 1'b0;
            w_shift    = {w_cur[6:0], 1'b0};
            w_sda_oe   = ~w_cur[7];
            w_ptr      = r_ptr + 2'd1;
            w_bit_cnt  = 4'd1;
            w_state    = S_RDATA;
          end
        end

        default: begin
          w_sda_oe = 1'b0;
        end
      endcase
    end
  end

  assign SDA       = r_sda_oe ? 1'b0 : 1'bz;
  assign regs_out  = r_regs;
  assign wr_strobe = r_wr_strobe;
  assign wr_ptr    = r_wr_ptr;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
// ============================================================================
// Module      : tb_i2c_slave_regs
// Description : Directed bus-master bench for i2c_slave_regs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave_regs;

  logic        clk;
  logic        rst;
  logic        m_scl;
  logic        m_sda_low;
  wire         sda_bus;
  logic [31:0] regs_out;
  logic        wr_strobe;
  logic [1:0]  wr_ptr;
  logic        busy;

  int n_total;
  int n_pass;

  int         n_strobe;
  int         n_busy;
  int         n_slave_low;
  logic [1:0] strobe_log [0:255];

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_regs #(
    .SLAVE_ADDR(7'h50),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SCL      (m_scl),
    .SDA      (sda_bus),
    .regs_out (regs_out),
    .wr_strobe(wr_strobe),
    .wr_ptr   (wr_ptr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_strobe    = 0;
    n_busy      = 0;
    n_slave_low = 0;
  end

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_log[n_strobe[7:0]] = wr_ptr;
      n_strobe = n_strobe + 1;
    end
    if (busy) n_busy = n_busy + 1;
    if (!m_sda_low && sda_bus === 1'b0) n_slave_low = n_slave_low + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Works from bus idle and as a repeated START with SCL low.
  task automatic i2c_start();
    wclk(6);  m_sda_low = 1'b0;
    wclk(4);  m_scl = 1'b1;
    wclk(8);  m_sda_low = 1'b1;
    wclk(8);  m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(5);  m_sda_low = 1'b1;
    wclk(5);  m_scl = 1'b1;
    wclk(8);  m_sda_low = 1'b0;
    wclk(10);
  endtask

  task automatic send_bit(input logic b);
    wclk(5);  m_sda_low = ~b;
    wclk(5);  m_scl = 1'b1;
    wclk(10); m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    wclk(5);  m_sda_low = 1'b0;
    wclk(5);  m_scl = 1'b1;
    wclk(5);  ack = (sda_bus === 1'b0);
    wclk(5);  m_scl = 1'b0;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] data);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wclk(10); m_scl = 1'b1;
      wclk(5);  data[i] = (sda_bus !== 1'b0);
      wclk(5);  m_scl = 1'b0;
    end
    wclk(5);  m_sda_low = give_ack;
    wclk(5);  m_scl = 1'b1;
    wclk(10); m_scl = 1'b0;
    wclk(5);  m_sda_low = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  ptr_byte;
    logic [7:0]  data;
    logic [31:0] exp_regs;
    logic [1:0]  exp_wptr;
  } vec_t;

  initial begin
    vec_t       tbl [4];
    logic       ack;
    logic [7:0] d;
    int         s0;
    int         b0;
    int         l0;

    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    m_scl     = 1'b1;
    m_sda_low = 1'b0;

    tbl[0] = '{8'h00, 8'h12, 32'h7700_0012, 2'd0};
    tbl[1] = '{8'hFE, 8'h80, 32'h7780_0012, 2'd2};
    tbl[2] = '{8'h05, 8'hC3, 32'h7780_C312, 2'd1};
    tbl[3] = '{8'h03, 8'h01, 32'h0180_C312, 2'd3};

    wclk(4);
    check("rst_regs", regs_out, 32'h0);
    check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wrptr", {30'd0, wr_ptr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sda", {31'd0, sda_bus}, 32'd1);
    rst = 1'b0;
    wclk(5);

    // 1: single write
    s0 = n_strobe;
    i2c_start();
    send_byte(8'hA0, ack); check("t1_ack_addr", {31'd0, ack}, 32'd1);
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(8'h01, ack); check("t1_ack_ptr", {31'd0, ack}, 32'd1);
    send_byte(8'hA5, ack); check("t1_ack_data", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("t1_regs", regs_out, 32'h0000_A500);
    check("t1_nstrobe", n_strobe - s0, 32'd1);
    check("t1_wrptr", {30'd0, strobe_log[s0[7:0]]}, 32'd1);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2: burst write wrapping 3 -> 0
    s0 = n_strobe;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    send_byte(8'h11, ack); check("t2_ack0", {31'd0, ack}, 32'd1);
    send_byte(8'h22, ack); check("t2_ack1", {31'd0, ack}, 32'd1);
    send_byte(8'h33, ack); check("t2_ack2", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("t2_regs", regs_out, 32'h1100_3322);
    check("t2_nstrobe", n_strobe - s0, 32'd3);
    check("t2_wrptr0", {30'd0, strobe_log[s0[7:0]]}, 32'd3);
    check("t2_wrptr1", {30'd0, strobe_log[s0[7:0] + 8'd1]}, 32'd0);
    check("t2_wrptr2", {30'd0, strobe_log[s0[7:0] + 8'd2]}, 32'd1);

    // 3: pointer set, repeated START, two-byte read ending in NACK
    s0 = n_strobe;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h02, ack);
    i2c_start();
    send_byte(8'hA1, ack); check("t3_ack_raddr", {31'd0, ack}, 32'd1);
    read_byte(1'b1, d);    check("t3_rd0", {24'd0, d}, 32'h00);
    read_byte(1'b0, d);    check("t3_rd1", {24'd0, d}, 32'h11);
    wclk(6);
    check("t3_sda_released", {31'd0, sda_bus}, 32'd1);
    i2c_stop();
    check("t3_nstrobe", n_strobe - s0, 32'd0);
    check("t3_regs", regs_out, 32'h1100_3322);

    // 4: foreign address
    b0 = n_busy;
    l0 = n_slave_low;
    i2c_start();
    send_byte(8'hA2, ack); check("t4_nack", {31'd0, ack}, 32'd0);
    send_byte(8'h00, ack);
    send_byte(8'hFF, ack);
    i2c_stop();
    check("t4_no_drive", n_slave_low - l0, 32'd0);
    check("t4_no_busy", n_busy - b0, 32'd0);
    check("t4_regs", regs_out, 32'h1100_3322);

    // 5: STOP inside a data byte, then a clean write
    s0 = n_strobe;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    check("t5_abort_regs", regs_out, 32'h1100_3322);
    check("t5_abort_nstrobe", n_strobe - s0, 32'd0);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    send_byte(8'h5A, ack); check("t5_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("t5_regs", regs_out, 32'h1100_335A);

    // 6: reset while a read holds SDA low (pointer 1 -> reg1 = 0x33, MSB 0)
    i2c_start();
    send_byte(8'hA1, ack);
    wclk(6);
    check("t6_driving", {31'd0, sda_bus}, 32'd0);
    rst = 1'b1;
    wclk(1);
    rst = 1'b0;
    check("t6_sda_z", {31'd0, sda_bus}, 32'd1);
    check("t6_regs", regs_out, 32'h0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, ack); check("t6_ack_addr", {31'd0, ack}, 32'd1);
    send_byte(8'h03, ack);
    send_byte(8'h77, ack); check("t6_ack_data", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("t6_regs_after", regs_out, 32'h7700_0000);

    // Table: single writes with pointer masking, each read back
    for (int k = 0; k < 4; k++) begin
      s0 = n_strobe;
      i2c_start();
      send_byte(8'hA0, ack);
      send_byte(tbl[k].ptr_byte, ack);
      send_byte(tbl[k].data, ack);
      check($sformatf("tbl%0d_ack", k), {31'd0, ack}, 32'd1);
      i2c_stop();
      check($sformatf("tbl%0d_regs", k), regs_out, tbl[k].exp_regs);
      check($sformatf("tbl%0d_nstrobe", k), n_strobe - s0, 32'd1);
      check($sformatf("tbl%0d_wrptr", k), {30'd0, strobe_log[s0[7:0]]}, {30'd0, tbl[k].exp_wptr});
      i2c_start();
      send_byte(8'hA0, ack);
      send_byte(tbl[k].ptr_byte, ack);
      i2c_start();
      send_byte(8'hA1, ack);
      read_byte(1'b0, d);
      i2c_stop();
      check($sformatf("tbl%0d_readback", k), {24'd0, d}, {24'd0, tbl[k].data});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (slave) that sits directly downstream of mod_I2C on the SCL/SDA pair and consumes the bus transactions the master generates.
- Exposes four 8-bit registers, addressed through an internal 2-bit pointer, to on-chip logic.
- Serves as the loop-back endpoint for master bring-up and as the register port for peripheral control.
- Oversamples SCL/SDA on clk; it does not clock from SCL.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit device address matched after START
RESET_VAL, 32'h00000000, reset contents of the four registers (reg k = bits [8k+7:8k])

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
SCL  input  1  I2C clock from master (never stretched)
SDA  inout  1  I2C data; open-drain: driven 0 or Z only, never driven 1
regs_out  output  32  current register contents, reg k at [8k+7:8k]
wr_strobe  output  1  one-cycle pulse per data byte written
wr_ptr  output  2  register index written, valid with wr_strobe
busy  output  1  high from address match until STOP/START/abort

Behaviour:
Reset and interface rules:
- One clock: clk. Reset is synchronous, active-high on rst, and has priority over every other event.
- On reset: SDA released (Z), regs_out=RESET_VAL, wr_strobe=0, wr_ptr=0, busy=0, pointer=0, state IDLE.

Sampling and events:
- SCL and SDA each pass through a 2-flop synchronizer; all edges are detected on the synchronized copies (2-clk input latency).
- START: sync SDA falls while sync SCL is high.
- STOP: sync SDA rises while sync SCL is high.
- Data bits are sampled on sync SCL rising edges, MSB first.
- SDA output changes only on the cycle after a detected sync SCL falling edge.
- Requirement on the master: SCL low time >= 8 clk.

States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- START in any state -> ADDR, bit count cleared, SDA released. This covers repeated START.
- STOP in any state -> IDLE, SDA released, busy=0. A partial byte is discarded and registers are unchanged.
- ADDR: shift 8 bits.
  - Upper 7 bits == SLAVE_ADDR -> ADDR_ACK, busy=1.
  - Otherwise -> IGNORE: SDA never driven; wait for START/STOP.
- ADDR_ACK: drive SDA=0 from the falling edge after bit 8 until the falling edge after the 9th SCL pulse.
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA, loading the register at the pointer into the shift register.
- PTR: shift 8 bits; pointer <= byte[1:0] (bits [7:2] ignored); then PTR_ACK (ACK as above) -> WDATA.
- WDATA: shift 8 bits. On the 8th rising edge:
  - reg[pointer] <= byte.
  - wr_strobe=1 for exactly one clk, with wr_ptr=pointer.
  - Pointer increments, wrapping 3->0.
  - Then WDATA_ACK (ACK) -> WDATA.
- RDATA: drive bit 7 of the byte on the falling edge that ends the ACK; subsequent bits on each following falling edge. A data bit of 1 means release; 0 means drive low.
  - After 8 bits, release SDA -> RACK.
  - Pointer increments (wrap 3->0) once the byte is loaded.
- RACK: sample the master ACK on the 9th rising edge.
  - SDA=0 -> RDATA with the next register.
  - SDA=1 (NACK) -> IGNORE.
- Register write and regs_out update happen in the same clk as wr_strobe.
- Registers are otherwise only changed by reset.
- A read with no preceding pointer write uses the pointer left by the last transaction (0 after reset).

Test Plan:
1. Single write: S, 0xA0, 0x01, 0xA5, P -> three ACK slots with SDA=0; regs_out=0x0000A500; exactly one wr_strobe with wr_ptr=1; busy=0 after P.
2. Burst write with wrap: S, 0xA0, 0x03, then 0x11, 0x22, 0x33, P -> reg3=0x11, reg0=0x22, reg1=0x33; regs_out=0x11003322; three strobes with wr_ptr=3, 0, 1.
3. Read via repeated START, starting from the state left by test 2: S, 0xA0, 0x02, Sr, 0xA1; master ACKs the first byte and NACKs the second; then P -> bytes on SDA = 0x00 (reg2), 0x11 (reg3); SDA released after the NACK; no wr_strobe.
4. Address mismatch: S, 0xA2, 0x00, 0xFF, P -> SDA never driven low by the block; regs_out unchanged; busy stays 0.
5. Aborted write: S, 0xA0, 0x00, then 4 bits of 0xF0, then STOP -> regs_out unchanged; no wr_strobe; next transaction S, 0xA0, 0x00, 0x5A, P -> reg0=0x5A.
6. Reset mid-read: assert rst for 1 clk while the block is driving SDA=0 in RDATA -> SDA=Z on the next clk; regs_out=RESET_VAL; busy=0; state IDLE; a subsequent write transaction is ACKed normally.
